// File: rtl/bcd_pkg.sv
// bcd_pkg: shared segment constants, FSM state encoding and preset clamp for the BCD countdown timer.
package bcd_pkg;

    localparam logic [6:0] SEG_0       = 7'b1000000;
    localparam logic [6:0] SEG_1       = 7'b1111001;
    localparam logic [6:0] SEG_2       = 7'b0100100;
    localparam logic [6:0] SEG_3       = 7'b0110000;
    localparam logic [6:0] SEG_4       = 7'b0011001;
    localparam logic [6:0] SEG_5       = 7'b0010010;
    localparam logic [6:0] SEG_6       = 7'b0000010;
    localparam logic [6:0] SEG_7       = 7'b1111000;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0010000;
    localparam logic [6:0] SEG_DEFAULT = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] clamp_digit(input logic [3:0] i_d);
        return (i_d > 4'd9) ? 4'd9 : i_d;
    endfunction

    function automatic logic [11:0] clamp_bcd(input logic [11:0] i_p);
        return {clamp_digit(i_p[11:8]), clamp_digit(i_p[7:4]), clamp_digit(i_p[3:0])};
    endfunction

endpackage

// File: rtl/seg7_enc.sv
// seg7_enc: one BCD digit to active-low 7-segment pattern, bit order g..a.
module seg7_enc
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DEFAULT;
        endcase
    end

endmodule

// File: rtl/bcd3_down_counter.sv
// bcd3_down_counter: 3-digit BCD countdown timer with prescaler, terminal flag and 7-segment outputs.
// Define AUTO_RELOAD_EN to reload the last preset at terminal count instead of stopping.
module bcd3_down_counter
    import bcd_pkg::*;
#(
    parameter int DIV = 25000000,
    parameter int CW  = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [11:0] preset,
    output logic [6:0]  SG_0,
    output logic [6:0]  SG_1,
    output logic [6:0]  SG_2,
    output logic        d
);

    state_t          r_state, w_state_nxt;
    logic [11:0]     r_q, w_q_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_d, w_d_nxt;
    logic [11:0]     w_clamped, w_dec;
    logic            w_tick, w_b1, w_b2;

    assign w_clamped = clamp_bcd(preset);
    assign w_tick    = (r_cnt == CW'(DIV - 1));

    // Ripple-borrow BCD decrement; hundreds cannot underflow since RUN leaves at 000
    assign w_b1  = (r_q[3:0] == 4'd0);
    assign w_b2  = w_b1 && (r_q[7:4] == 4'd0);
    assign w_dec = {w_b2 ? r_q[11:8] - 4'd1 : r_q[11:8],
                    w_b1 ? ((r_q[7:4] == 4'd0) ? 4'd9 : r_q[7:4] - 4'd1) : r_q[7:4],
                    w_b1 ? 4'd9 : r_q[3:0] - 4'd1};

`ifdef AUTO_RELOAD_EN
    logic [11:0] r_preset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_preset <= '0;
        else if (load)
            r_preset <= w_clamped;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_d_nxt     = r_d;
        w_cnt_nxt   = r_cnt;
`ifdef AUTO_RELOAD_EN
        if (r_state == RUN)
            w_d_nxt = 1'b0;
`endif
        if (load) begin
            w_cnt_nxt   = '0;
            w_q_nxt     = w_clamped;
            w_state_nxt = (w_clamped == 12'h000) ? DONE : RUN;
            w_d_nxt     = (w_clamped == 12'h000);
        end else if (r_state == RUN && en) begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick) begin
                if (w_dec == 12'h000) begin
`ifdef AUTO_RELOAD_EN
                    w_q_nxt     = r_preset;
`else
                    w_q_nxt     = 12'h000;
                    w_state_nxt = DONE;
`endif
                    w_d_nxt     = 1'b1;
                end else begin
                    w_q_nxt = w_dec;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_d     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d     <= w_d_nxt;
        end
    end

    assign d = r_d;

    seg7_enc u_seg0 (.i_bcd(r_q[3:0]),  .o_seg(SG_0));
    seg7_enc u_seg1 (.i_bcd(r_q[7:4]),  .o_seg(SG_1));
    seg7_enc u_seg2 (.i_bcd(r_q[11:8]), .o_seg(SG_2));

endmodule

// File: tb/tb_bcd3_down_counter.sv
// tb_bcd3_down_counter: scoreboard bench; a decimal countdown model predicts segments and d each clock.
module tb_bcd3_down_counter;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [11:0] preset = '0;
    logic [6:0]  SG_0, SG_1, SG_2;
    logic        d;

    int checks = 0;
    int errors = 0;

    int   m_val, m_pre, m_cnt;
    logic m_run, m_d;
    logic [21:0] sb_q[$];

    bcd3_down_counter #(.DIV(DIV), .CW(2)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .preset(preset),
        .SG_0(SG_0), .SG_1(SG_1), .SG_2(SG_2), .d(d)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [21:0] expect_vec(input int v, input logic dd);
        return {seg(v / 100), seg((v / 10) % 10), seg(v % 10), dd};
    endfunction

    function automatic int clamp_dec(input logic [11:0] p);
        int h, t, o;
        h = (p[11:8] > 4'd9) ? 9 : int'(p[11:8]);
        t = (p[7:4] > 4'd9) ? 9 : int'(p[7:4]);
        o = (p[3:0] > 4'd9) ? 9 : int'(p[3:0]);
        return h * 100 + t * 10 + o;
    endfunction

    task automatic model_reset();
        m_val = 0; m_pre = 0; m_cnt = 0; m_run = 1'b0; m_d = 1'b0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then check them
    task automatic cyc(input logic ld, input logic [11:0] p, input logic e, input string name);
        logic [21:0] exp_v, got;
        load = ld; preset = p; en = e;
        if (ld) begin
            m_val = clamp_dec(p); m_pre = m_val; m_cnt = 0;
            m_run = (m_val != 0); m_d = (m_val == 0);
        end else begin
`ifdef AUTO_RELOAD_EN
            if (m_run) m_d = 1'b0;
`endif
            if (m_run && e) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    if (m_val == 1) begin
`ifdef AUTO_RELOAD_EN
                        m_val = m_pre;
`else
                        m_val = 0; m_run = 1'b0;
`endif
                        m_d = 1'b1;
                    end else m_val = m_val - 1;
                end else m_cnt = m_cnt + 1;
            end
        end
        sb_q.push_back(expect_vec(m_val, m_d));
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        got = {SG_2, SG_1, SG_0, d};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (model q=%0d)", name, got, exp_v, m_val);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; #3; rst = 1'b0;
        model_reset();
        checks++;
        if ({SG_2, SG_1, SG_0, d} !== {7'b1000000, 7'b1000000, 7'b1000000, 1'b0}) begin
            errors++;
            $display("FAIL reset got=%b/%b/%b d=%b", SG_2, SG_1, SG_0, d);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 12'h000, 1'b1, "idle");
    endtask

    task automatic test_count_down();
        cyc(1'b1, 12'h012, 1'b1, "load012");
        for (int i = 0; i < 30; i++) cyc(1'b0, 12'h000, 1'b1, "count012");
        checks++;
        if (SG_0 !== 7'b1000000 || d !== 1'b1) begin
            errors++;
            $display("FAIL done_hold SG_0=%b d=%b exp 1000000/1", SG_0, d);
        end
    endtask

    task automatic test_double_borrow();
        cyc(1'b1, 12'h100, 1'b1, "load100");
        cyc(1'b0, 12'h000, 1'b1, "b100_a");
        cyc(1'b0, 12'h000, 1'b1, "b100_b");
        checks++;
        if (SG_2 !== 7'b1000000 || SG_1 !== 7'b0010000 || SG_0 !== 7'b0010000) begin
            errors++;
            $display("FAIL borrow099 got=%b/%b/%b exp 1000000/0010000/0010000", SG_2, SG_1, SG_0);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 12'h000, 1'b1, "b100_run");
    endtask

    task automatic test_freeze_override();
        cyc(1'b1, 12'h005, 1'b1, "load005");
        for (int i = 0; i < 6; i++) cyc(1'b0, 12'h000, 1'b0, "freeze");
        cyc(1'b0, 12'h000, 1'b1, "unfreeze");
        cyc(1'b1, 12'h030, 1'b1, "load_on_tick");
        for (int i = 0; i < 3; i++) cyc(1'b0, 12'h000, 1'b1, "run030");
        cyc(1'b1, 12'hFFF, 1'b1, "clampFFF");
        cyc(1'b1, 12'hAF3, 1'b1, "clampAF3");
        cyc(1'b0, 12'h000, 1'b1, "run993");
        cyc(1'b1, 12'h000, 1'b1, "load000");
        cyc(1'b0, 12'h000, 1'b1, "done000");
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 12'h050, 1'b1, "load050");
        for (int i = 0; i < 5; i++) cyc(1'b0, 12'h000, 1'b1, "run050");
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({SG_2, SG_1, SG_0, d} !== {7'b1000000, 7'b1000000, 7'b1000000, 1'b0}) begin
            errors++;
            $display("FAIL async_rst got=%b/%b/%b d=%b", SG_2, SG_1, SG_0, d);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 12'h000, 1'b1, "post_rst");
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        cyc(1'b1, 12'h002, 1'b1, "load002");
        for (int i = 0; i < 16; i++) cyc(1'b0, 12'h000, 1'b1, "auto");
    endtask
`endif

    initial begin
        model_reset();
        #2;
        test_reset();
        test_count_down();
        test_double_borrow();
        test_freeze_override();
        test_async_reset();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
